// File: rtl/phase_capture_deadlock_pkg.sv
// rtl/phase_capture_deadlock_pkg.sv - shared types and sizing for the deadlock report collector
package phase_capture_deadlock_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      REPORT,
      HOLD
   } state_t;

   localparam int IDX_W = 4;

   // Counter must hold THRESH itself without wrapping.
   function automatic int cnt_width(input int thresh);
      return $clog2(thresh + 1);
   endfunction

endpackage

// File: rtl/phase_capture_prio_enc.sv
// rtl/phase_capture_prio_enc.sv - lowest-set-bit encoder over the monitor block vector
module phase_capture_prio_enc
   import phase_capture_deadlock_pkg::*;
#(
   parameter int NUM_MON = 4
) (
   input  logic [NUM_MON-1:0] mon_block,
   output logic [IDX_W-1:0]   cand,
   output logic               any
);

   // Scan downward so the lowest asserted index is the last one written.
   always_comb begin
      cand = '0;
      for (int i = NUM_MON - 1; i >= 0; i--) begin
         if (mon_block[i]) begin
            cand = IDX_W'(i);
         end
      end
   end

   assign any = |mon_block;

endmodule

// File: rtl/phase_capture_hls_deadlock_report_collector.sv
// rtl/phase_capture_hls_deadlock_report_collector.sv - qualifies persistent monitor blocks and presents one report per episode
module phase_capture_hls_deadlock_report_collector
   import phase_capture_deadlock_pkg::*;
#(
   parameter int NUM_MON = 4,
   parameter int INFO_W  = 1,
   parameter int THRESH  = 1024,
   parameter int TS_W    = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_MON-1:0]        mon_block,
   input  logic [NUM_MON*INFO_W-1:0] mon_info,
   input  logic                      clear,
   output logic                      report_valid,
   input  logic                      report_ready,
   output logic [IDX_W-1:0]          report_idx,
   output logic [INFO_W-1:0]         report_info,
   output logic [TS_W-1:0]           report_ts,
   output logic                      deadlock
);

   localparam int CNT_W = cnt_width(THRESH);

   state_t             state, state_n;
   logic [TS_W-1:0]    ts;
   logic [IDX_W-1:0]   trk_idx, trk_idx_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [TS_W-1:0]    first_ts, first_ts_n;
   logic               load_report;
   logic [IDX_W-1:0]   cand;
   logic               any;
   logic               trk_blk;
   logic [INFO_W-1:0]  trk_info;

   phase_capture_prio_enc #(
      .NUM_MON (NUM_MON)
   ) u_prio_enc (
      .mon_block (mon_block),
      .cand      (cand),
      .any       (any)
   );

   // Mux out the tracked monitor's block bit and info slice.
   always_comb begin
      trk_blk  = 1'b0;
      trk_info = '0;
      for (int i = 0; i < NUM_MON; i++) begin
         if (trk_idx == IDX_W'(i)) begin
            trk_blk  = mon_block[i];
            trk_info = mon_info[i*INFO_W +: INFO_W];
         end
      end
   end

   always_comb begin
      state_n     = state;
      trk_idx_n   = trk_idx;
      cnt_n       = cnt;
      first_ts_n  = first_ts;
      load_report = 1'b0;
      case (state)
         IDLE: begin
            if (any) begin
               state_n    = COUNT;
               trk_idx_n  = cand;
               cnt_n      = CNT_W'(1);
               first_ts_n = ts;
            end
         end
         COUNT: begin
            if (!trk_blk && any) begin
               trk_idx_n  = cand;
               cnt_n      = CNT_W'(1);
               first_ts_n = ts;
            end else if (!any) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (cnt == CNT_W'(THRESH)) begin
               state_n     = REPORT;
               load_report = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         REPORT: begin
            if (report_ready) begin
               state_n = HOLD;
            end
         end
         HOLD: begin
            // Wait for the episode to end so it cannot be reported twice.
            if (!any) begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
      if (clear) begin
         state_n     = IDLE;
         cnt_n       = '0;
         load_report = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         ts          <= '0;
         trk_idx     <= '0;
         cnt         <= '0;
         first_ts    <= '0;
         report_idx  <= '0;
         report_info <= '0;
         report_ts   <= '0;
         deadlock    <= 1'b0;
      end else begin
         state    <= state_n;
         trk_idx  <= trk_idx_n;
         cnt      <= cnt_n;
         first_ts <= first_ts_n;
         if (ts != {TS_W{1'b1}}) begin
            ts <= ts + TS_W'(1);
         end
         if (load_report) begin
            report_idx  <= trk_idx;
            report_info <= trk_info;
            report_ts   <= first_ts;
         end
         if (clear) begin
            deadlock <= 1'b0;
         end else if (load_report) begin
            deadlock <= 1'b1;
         end
      end
   end

   assign report_valid = (state == REPORT);

endmodule

// File: tb/tb_phase_capture_hls_deadlock_report_collector.sv
// tb/tb_phase_capture_hls_deadlock_report_collector.sv - directed self-checking bench for the deadlock report collector
module tb_phase_capture_hls_deadlock_report_collector;

   localparam int NUM_MON = 4;
   localparam int INFO_W  = 1;
   localparam int THRESH  = 16;
   localparam int TS_W    = 32;

   logic                      clock = 1'b0;
   logic                      reset;
   logic [NUM_MON-1:0]        mon_block;
   logic [NUM_MON*INFO_W-1:0] mon_info;
   logic                      clear;
   logic                      report_valid;
   logic                      report_ready;
   logic [3:0]                report_idx;
   logic [INFO_W-1:0]         report_info;
   logic [TS_W-1:0]           report_ts;
   logic                      deadlock;

   int total = 0;
   int bad   = 0;
   logic [TS_W-1:0] now = '0;
   logic [TS_W-1:0] start;
   logic            seen;
   logic            hold_ok;

   phase_capture_hls_deadlock_report_collector #(
      .NUM_MON (NUM_MON),
      .INFO_W  (INFO_W),
      .THRESH  (THRESH),
      .TS_W    (TS_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .mon_block    (mon_block),
      .mon_info     (mon_info),
      .clear        (clear),
      .report_valid (report_valid),
      .report_ready (report_ready),
      .report_idx   (report_idx),
      .report_info  (report_info),
      .report_ts    (report_ts),
      .deadlock     (deadlock)
   );

   always #5 clock = ~clock;

   // now tracks the DUT timestamp value between edges.
   task automatic step();
      logic r;
      r = reset;
      @(posedge clock);
      #1;
      now = r ? '0 : now + 1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      mon_block    = '0;
      mon_info     = '0;
      clear        = 1'b0;
      report_ready = 1'b0;
      steps(3);
      chk("rst_valid", report_valid, 0);
      chk("rst_deadlock", deadlock, 0);
      chk("rst_idx", report_idx, 0);
      chk("rst_info", report_info, 0);
      chk("rst_ts", report_ts, 0);
      reset = 1'b0;

      // Long quiet period.
      seen = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         step();
         seen = seen | report_valid | deadlock;
      end
      chk("idle_quiet", seen, 0);

      // Basic qualification on monitor 2.
      mon_block    = 4'b0100;
      mon_info     = 4'b0100;
      report_ready = 1'b1;
      start        = now;
      steps(THRESH);
      chk("basic_early", report_valid, 0);
      chk("basic_early_dl", deadlock, 0);
      step();
      chk("basic_valid", report_valid, 1);
      chk("basic_deadlock", deadlock, 1);
      chk("basic_idx", report_idx, 2);
      chk("basic_info", report_info, 1);
      chk("basic_ts", report_ts, start);
      step();
      chk("basic_handshake", report_valid, 0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         seen = seen | report_valid;
      end
      chk("basic_no_second", seen, 0);
      mon_block = '0;
      step();
      chk("basic_sticky", deadlock, 1);
      pulse_clear();
      chk("clear_deadlock", deadlock, 0);

      // Gap of one cycle restarts the count.
      mon_block = 4'b0010;
      mon_info  = 4'b0010;
      seen      = 1'b0;
      for (int i = 0; i < THRESH - 1; i++) begin
         step();
         seen = seen | report_valid;
      end
      mon_block = '0;
      step();
      seen = seen | report_valid;
      mon_block = 4'b0010;
      start     = now;
      for (int i = 0; i < THRESH; i++) begin
         step();
         seen = seen | report_valid;
      end
      chk("gap_no_early", seen, 0);
      step();
      chk("gap_valid", report_valid, 1);
      chk("gap_idx", report_idx, 1);
      chk("gap_ts", report_ts, start);
      step();
      mon_block = '0;
      step();
      pulse_clear();

      // Tracked monitor drops while a higher one stays blocked.
      mon_block = 4'b1010;
      mon_info  = 4'b1000;
      steps(8);
      mon_block = 4'b1000;
      start     = now;
      steps(THRESH);
      chk("restart_early", report_valid, 0);
      step();
      chk("restart_valid", report_valid, 1);
      chk("restart_idx", report_idx, 3);
      chk("restart_info", report_info, 1);
      chk("restart_ts", report_ts, start);
      step();
      mon_block = '0;
      step();
      pulse_clear();

      // Backpressure: report must hold steady while ready is low.
      report_ready = 1'b0;
      mon_block    = 4'b1010;
      mon_info     = 4'b0000;
      start        = now;
      steps(THRESH + 1);
      chk("bp_valid", report_valid, 1);
      chk("bp_idx", report_idx, 1);
      chk("bp_info", report_info, 0);
      chk("bp_ts", report_ts, start);
      mon_info = 4'b1111;
      hold_ok  = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         if (report_valid !== 1'b1 || report_idx !== 4'd1 || report_info !== 1'b0 || report_ts !== start)
            hold_ok = 1'b0;
      end
      chk("bp_stable", hold_ok, 1);
      report_ready = 1'b1;
      step();
      chk("bp_release", report_valid, 0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         seen = seen | report_valid;
      end
      chk("hold_no_second", seen, 0);
      mon_block = '0;
      step();
      mon_block    = 4'b0100;
      report_ready = 1'b0;
      start        = now;
      steps(THRESH + 1);
      chk("rearm_valid", report_valid, 1);
      chk("rearm_idx", report_idx, 2);
      chk("rearm_info", report_info, 1);
      chk("rearm_ts", report_ts, start);
      chk("rearm_deadlock", deadlock, 1);

      // Clear coinciding with the handshake wins.
      clear        = 1'b1;
      report_ready = 1'b1;
      step();
      clear        = 1'b0;
      report_ready = 1'b0;
      chk("clear_valid", report_valid, 0);
      chk("clear_dl", deadlock, 0);

      // Reset in the middle of counting.
      steps(4);
      reset = 1'b1;
      step();
      chk("midrst_valid", report_valid, 0);
      chk("midrst_deadlock", deadlock, 0);
      chk("midrst_idx", report_idx, 0);
      chk("midrst_info", report_info, 0);
      chk("midrst_ts", report_ts, 0);
      reset     = 1'b0;
      mon_block = '0;
      steps(2);
      chk("post_rst_quiet", report_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
